// File: rtl/display_controller_vm.sv
`default_nettype none
// ============================================================================
//  Module   : display_controller_vm
//  Purpose  : Seven-segment driver for the three-floor elevator. Decodes the
//             2-bit floor code into segments a..g ("1", "2", "3", or "-" for
//             no floor) and optionally blinks the digit while ip is high.
//  Options  : DISPLAY_ACTIVE_LOW_EN - invert all segment outputs for
//             common-anode displays (0 = lit).
//  Revision : 1.0 - initial release
// ============================================================================
module display_controller_vm #(
   parameter int BLINK_HALF = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic i0,
   input  logic i1,
   input  logic ip,
   output logic a,
   output logic b,
   output logic c,
   output logic d,
   output logic e,
   output logic f,
   output logic g
);

   localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [CW-1:0] C_CNT_LAST = CW'(BLINK_HALF - 1);

   // Polarity mask XORed onto the active-high pattern; also the "dark" value.
`ifdef DISPLAY_ACTIVE_LOW_EN
   localparam logic [6:0] C_POL_MASK = 7'b111_1111;
`else
   localparam logic [6:0] C_POL_MASK = 7'b000_0000;
`endif

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;
   logic [6:0]    seg_q, seg_d;     // bit 6 = a ... bit 0 = g, already polarity-adjusted
   logic [6:0]    digit_w;

   // Floor code to active-high segment pattern {a,b,c,d,e,f,g}.
   always_comb begin
      digit_w = 7'b000_0001;
      case ({i1, i0})
         2'b01:   digit_w = 7'b011_0000;
         2'b10:   digit_w = 7'b110_1101;
         2'b11:   digit_w = 7'b111_1001;
         default: digit_w = 7'b000_0001;
      endcase
   end

   // Blink timer next state and the next segment value (uses pre-update phase).
   always_comb begin
      cnt_d   = '0;
      phase_d = 1'b0;
      seg_d   = digit_w ^ C_POL_MASK;
      if (ip) begin
         if (cnt_q == C_CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d   = cnt_q + 1'b1;
            phase_d = phase_q;
         end
         if (phase_q) begin
            seg_d = C_POL_MASK;
         end
      end
   end

   // State and output registers; reset darkens the display and restarts blinking.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
         seg_q   <= C_POL_MASK;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         seg_q   <= seg_d;
      end
   end

   assign {a, b, c, d, e, f, g} = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_display_controller_vm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_controller_vm
//  Purpose  : Scoreboard bench for display_controller_vm. Two instances
//             (BLINK_HALF = 2 and 1) share stimulus; expected segment values
//             come from an episode-age model of the blink schedule.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_display_controller_vm;

   localparam int BH0 = 2;
   localparam int BH1 = 1;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       i0 = 1'b0;
   logic       i1 = 1'b0;
   logic       ip = 1'b0;
   logic [6:0] seg0, seg1;

   int n_checks = 0;
   int n_fail   = 0;
   bit started  = 1'b0;

   logic [6:0] q0[$];
   logic [6:0] q1[$];
   int age0 = 0;
   int age1 = 0;

   display_controller_vm #(.BLINK_HALF(BH0)) u_dut0 (
      .clock(clock), .reset(reset), .i0(i0), .i1(i1), .ip(ip),
      .a(seg0[6]), .b(seg0[5]), .c(seg0[4]), .d(seg0[3]),
      .e(seg0[2]), .f(seg0[1]), .g(seg0[0])
   );

   display_controller_vm #(.BLINK_HALF(BH1)) u_dut1 (
      .clock(clock), .reset(reset), .i0(i0), .i1(i1), .ip(ip),
      .a(seg1[6]), .b(seg1[5]), .c(seg1[4]), .d(seg1[3]),
      .e(seg1[2]), .f(seg1[1]), .g(seg1[0])
   );

   always #5 clock = ~clock;

   // Lit segments for each floor code, as a table of abcdefg strings' bits.
   function automatic logic [6:0] pattern(input logic [1:0] code);
      logic [6:0] tbl [4];
      tbl[0] = 7'b0000001;  // "-"
      tbl[1] = 7'b0110000;  // "1"
      tbl[2] = 7'b1101101;  // "2"
      tbl[3] = 7'b1111001;  // "3"
      return tbl[code];
   endfunction

   function automatic logic [6:0] pol(input logic [6:0] s);
`ifdef DISPLAY_ACTIVE_LOW_EN
      return ~s;
`else
      return s;
`endif
   endfunction

   // Display at an edge: during an ip episode, edge number n (from 0) is
   // blank when floor(n / half) is odd.
   function automatic logic [6:0] expect_seg(input logic r, input logic [1:0] code,
                                             input logic p, input int age, input int half);
      if (r)                           return pol(7'b0);
      if (p && (((age / half) % 2) == 1)) return pol(7'b0);
      return pol(pattern(code));
   endfunction

   task automatic drive(input logic r, input logic [1:0] code, input logic p);
      @(negedge clock);
      reset = r;
      {i1, i0} = code;
      ip = p;
      q0.push_back(expect_seg(r, code, p, age0, BH0));
      q1.push_back(expect_seg(r, code, p, age1, BH1));
      if (r || !p) begin
         age0 = 0;
         age1 = 0;
      end else begin
         age0++;
         age1++;
      end
      started = 1'b1;
   endtask

   task automatic repeat_drive(input int n, input logic r, input logic [1:0] code, input logic p);
      for (int k = 0; k < n; k++) drive(r, code, p);
   endtask

   // Monitor: the output register presents a new value every edge.
   always @(posedge clock) begin
      #1;
      if (started) begin
         logic [6:0] e0, e1;
         n_checks += 2;
         if (q0.size() == 0 || q1.size() == 0) begin
            n_fail++;
            $display("FAIL underflow: scoreboard empty at t=%0t (sizes %0d %0d, required >0)",
                     $time, q0.size(), q1.size());
         end else begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            if (seg0 !== e0) begin
               n_fail++;
               $display("FAIL seg_half2 t=%0t: got %b, required %b", $time, seg0, e0);
            end
            if (seg1 !== e1) begin
               n_fail++;
               $display("FAIL seg_half1 t=%0t: got %b, required %b", $time, seg1, e1);
            end
         end
      end
   end

   initial begin
      logic [1:0] rc;
      logic       rp;
      // Reset held two cycles, then a steady "1".
      repeat_drive(2, 1'b1, 2'b11, 1'b1);
      repeat_drive(2, 1'b0, 2'b01, 1'b0);
      // Steady decode of every code.
      repeat_drive(4, 1'b0, 2'b10, 1'b0);
      repeat_drive(4, 1'b0, 2'b11, 1'b0);
      repeat_drive(4, 1'b0, 2'b00, 1'b0);
      // Plain blink.
      repeat_drive(8, 1'b0, 2'b01, 1'b1);
      repeat_drive(1, 1'b0, 2'b01, 1'b0);
      // Code change during on-phase, schedule must hold.
      repeat_drive(1, 1'b0, 2'b01, 1'b1);
      repeat_drive(5, 1'b0, 2'b11, 1'b1);
      // ip dropped in off-phase, then a fresh episode.
      repeat_drive(1, 1'b0, 2'b01, 1'b0);
      repeat_drive(3, 1'b0, 2'b01, 1'b1);
      repeat_drive(1, 1'b0, 2'b01, 1'b0);
      repeat_drive(4, 1'b0, 2'b01, 1'b1);
      // ip rise together with a code change.
      repeat_drive(1, 1'b0, 2'b00, 1'b0);
      repeat_drive(3, 1'b0, 2'b10, 1'b1);
      // Reset mid-blink restarts the sequence.
      repeat_drive(1, 1'b1, 2'b10, 1'b1);
      repeat_drive(5, 1'b0, 2'b10, 1'b1);
      // Randomized traffic with held ip episodes and occasional resets.
      rp = 1'b0;
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 5) == 0) rp = ~rp;
         rc = 2'($urandom_range(0, 3));
         drive(($urandom_range(0, 39) == 0), rc, rp);
      end
      // Drain the last expected value, then confirm nothing is left over.
      @(negedge clock);
      started = 1'b0;
      @(negedge clock);
      n_checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_fail++;
         $display("FAIL drain: leftover entries %0d/%0d, required 0/0", q0.size(), q1.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/display_controller_vm.md
# display_controller_vm

Seven-segment display driver for the three-floor elevator: converts the 2-bit floor code {i1,i0} into segment outputs a–g showing "1", "2" or "3". When ip is asserted the digit blinks, signalling the car is moving or a request is pending. It sits between the elevator FSM (floor code and blink request) and the physical display pins.

## Interface
- BLINK_HALF, default 2: cycles per blink phase, on or off. Legal range ≥1.
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i0  input  1  floor code bit 0.
- i1  input  1  floor code bit 1.
- ip  input  1  blink enable; 1 = intermittent display.
- a, b, c, d, e, f, g  output  1 each  segment drives, registered; active-high (1 = lit) by default.

## Operation
- Decode of {i1,i0}, segments listed as lit:
  - 01 → "1": b, c
  - 10 → "2": a, b, d, e, g
  - 11 → "3": a, b, c, d, g
  - 00 → "-": g only. This is the invalid/no-floor indication.
- Blink state: counter cnt (0..BLINK_HALF-1, width clog2(BLINK_HALF) with min 1) and phase bit; phase 0 = on, 1 = off.
- While ip=1, each edge: if cnt==BLINK_HALF-1 then cnt←0 and phase←~phase, else cnt←cnt+1.
- While ip=0, each edge: cnt←0 and phase←0. Every new blink episode therefore starts with a full on-phase.
- Output register on each edge:
  - If ip=1 and phase=1 (pre-update value): all segments off.
  - Otherwise: the decoded pattern of the currently sampled {i1,i0}.
- Floor code changes during blinking affect the digit immediately on the next edge. They do not disturb the blink phase.
- Inputs are used as sampled at the edge; no internal synchronizers. Upstream logic supplies synchronous signals.

## Timing
- Latency: 1 clock from an input change to the output change.
- Reset (synchronous, highest priority): segments all off (0), cnt=0, phase=0. Reset asserted mid-blink restarts the sequence.
- With ip=1 first sampled at edge k, the display is:
  - digit at edges k … k+BLINK_HALF-1
  - blank at edges k+BLINK_HALF … k+2·BLINK_HALF-1
  - repeating with period 2·BLINK_HALF.
- ip falling: the digit is shown steadily from the next edge, even if the display was in the off phase.
- BLINK_HALF=1: the display alternates digit/blank every cycle.
- Simultaneous ip rise and code change at one edge: the new digit appears at that edge (on-phase).

## Configuration
- DISPLAY_ACTIVE_LOW_EN:
  - Defined: all seven outputs are inverted for common-anode displays (0 = lit). Reset value and the blink-off value become all 1s; "-" becomes only g=0.
  - Undefined: active-high as described above.

## Test plan
- Reset held 2 cycles with any inputs → a..g = 0000000; release with {i1,i0}=01, ip=0 → next edge abcdefg = 0110000.
- Steady decode, ip=0: {i1,i0}=10 → 1101101; 11 → 1111001; 00 → 0000001. Each value must hold for 4 cycles.
- Blink, BLINK_HALF=2, {i1,i0}=01, ip=1 for 8 cycles → 0110000, 0110000, 0000000, 0000000, repeating.
- Mid-blink code change from 01 to 11 during the on-phase → the next edge shows 1111001; the off-phase still occurs on the original schedule.
- ip dropped during the off-phase → the digit appears at the next edge; raising ip again → a full 2-cycle on-phase first.
- With DISPLAY_ACTIVE_LOW_EN defined: reset → 1111111; {i1,i0}=11, ip=0 → 0000110.
